// File: rtl/ptp_tx_gen.sv
// ---------------------------------------------------------------------------
// ptp_tx_gen
//   Builds PTP event/general frames (Sync, Delay_Req, Delay_Resp) as a fixed
//   six-word burst: metadata word 0, metadata word 1, Ethernet header, and
//   three PTP body words. The last word carries the frame's timestamp and is
//   accompanied by a frame descriptor strobe.
//
// Ports
//   clk              rising-edge clock
//   reset            synchronous, active-high
//   ptp_send_req     one-cycle request pulse from ptp_ctrl
//   ptp_send_type    1=Sync, 3=Delay_Req, 4=Delay_Resp
//   key              [5:0] out_port, [53:6] destination MAC (0 = PTP multicast)
//   ts_4_time        receive timestamp reported in Delay_Resp
//   timer            local time, sampled into the metadata word
//   ptp_send_ack     one-cycle pulse when a request is taken
//   outptp_data_wr   word strobe
//   outptp_data      [133:132] 01 head / 11 middle / 10 tail,
//                    [131:128] invalid byte count, [127:0] data
//   outptp_valid_wr  frame-descriptor strobe (tail cycle)
//   outptp_valid     descriptor value, 1 = forward frame
//   outptp_ready     downstream can take one full frame (checked in IDLE)
//   ts_1_valid       pulse when a Sync origin timestamp is issued
//   ts_1             origin timestamp of the last Sync
//   tx_t1_count      Sync frames sent
//   tx_t3_count      Delay_Req frames sent
//   tx_t4_count      Delay_Resp frames sent
//   dbg_state        current FSM state
//
// Handshake: a request is taken only in a cycle where the FSM is IDLE and
// ptp_send_req and outptp_ready are both 1 at the same rising edge; the
// block answers with ptp_send_ack in the following cycle. Requests seen at
// any other edge are ignored and must be repeated by the requester. There is
// no stall once a frame has started: one word is strobed every cycle until
// the tail.
// ---------------------------------------------------------------------------
module ptp_tx_gen #(
   parameter logic [47:0] LOCAL_MAC = 48'h0,
   parameter logic [47:0] PTP_DMAC  = 48'h011B19000000,
   parameter logic [15:0] ETH_TYPE  = 16'h88F7
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         ptp_send_req,
   input  logic [3:0]   ptp_send_type,
   input  logic [53:0]  key,
   input  logic [47:0]  ts_4_time,
   input  logic [47:0]  timer,
   output logic         ptp_send_ack,
   output logic         outptp_data_wr,
   output logic [133:0] outptp_data,
   output logic         outptp_valid_wr,
   output logic         outptp_valid,
   input  logic         outptp_ready,
   output logic         ts_1_valid,
   output logic [47:0]  ts_1,
   output logic [31:0]  tx_t1_count,
   output logic [31:0]  tx_t3_count,
   output logic [31:0]  tx_t4_count,
   output logic [2:0]   dbg_state
);

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      MD0  = 3'd1,
      MD1  = 3'd2,
      ETH  = 3'd3,
      PTP1 = 3'd4,
      PTP2 = 3'd5,
      PTP3 = 3'd6
   } state_t;

   localparam logic [3:0] TYPE_SYNC  = 4'd1;
   localparam logic [3:0] TYPE_DREQ  = 4'd3;
   localparam logic [3:0] TYPE_DRESP = 4'd4;

   localparam logic [1:0] HDR_HEAD = 2'b01;
   localparam logic [1:0] HDR_MID  = 2'b11;
   localparam logic [1:0] HDR_TAIL = 2'b10;

   state_t         state_q;
   logic [3:0]     type_q;
   logic [53:0]    key_q;
   logic [47:0]    ts4_q;
   logic [47:0]    t_md_q;
   logic           ack_q;
   logic           data_wr_q;
   logic [133:0]   data_q;
   logic           valid_wr_q;
   logic           valid_q;
   logic           ts_1_valid_q;
   logic [47:0]    ts_1_q;
   logic [31:0]    t1_cnt_q;
   logic [31:0]    t3_cnt_q;
   logic [31:0]    t4_cnt_q;

   logic [133:0]   word_d;
   logic [47:0]    dmac_d;
   logic [47:0]    ts_field_d;
   logic           type_ok_d;

   // A zero MAC in the request key means "use the PTP multicast address".
   assign dmac_d    = (key_q[53:6] != 48'h0) ? key_q[53:6] : PTP_DMAC;
   assign type_ok_d = (ptp_send_type == TYPE_SYNC) ||
                      (ptp_send_type == TYPE_DREQ) ||
                      (ptp_send_type == TYPE_DRESP);

   // Timestamp placed in the tail word. Sync reuses the metadata sample so the
   // origin timestamp matches the time the frame entered the pipeline.
   always_comb begin
      ts_field_d = 48'h0;
      case (type_q)
         TYPE_SYNC:  ts_field_d = t_md_q;
         TYPE_DRESP: ts_field_d = ts4_q;
         default:    ts_field_d = 48'h0;
      endcase
   end

   // Word to be strobed in the current state.
   always_comb begin
      word_d = 134'h0;
      case (state_q)
         MD0: begin
            word_d[133:132] = HDR_HEAD;
            word_d[125:120] = key_q[5:0];
            word_d[47:0]    = timer;
         end
         MD1: begin
            word_d[133:132] = HDR_MID;
         end
         ETH: begin
            word_d[133:132] = HDR_MID;
            word_d[127:80]  = dmac_d;
            word_d[79:32]   = LOCAL_MAC;
            word_d[31:16]   = ETH_TYPE;
            word_d[11:8]    = type_q;
         end
         PTP1: begin
            // correctionField [79:16] is left at zero.
            word_d[133:132] = HDR_MID;
         end
         PTP2: begin
            word_d[133:132] = HDR_MID;
         end
         PTP3: begin
            word_d[133:132] = HDR_TAIL;
            word_d[95:48]   = ts_field_d;
         end
         default: word_d = 134'h0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= IDLE;
         type_q       <= 4'h0;
         key_q        <= 54'h0;
         ts4_q        <= 48'h0;
         t_md_q       <= 48'h0;
         ack_q        <= 1'b0;
         data_wr_q    <= 1'b0;
         data_q       <= 134'h0;
         valid_wr_q   <= 1'b0;
         valid_q      <= 1'b0;
         ts_1_valid_q <= 1'b0;
         ts_1_q       <= 48'h0;
         t1_cnt_q     <= 32'h0;
         t3_cnt_q     <= 32'h0;
         t4_cnt_q     <= 32'h0;
      end else begin
         // Pulses default low; data_q holds its last value.
         ack_q        <= 1'b0;
         data_wr_q    <= 1'b0;
         valid_wr_q   <= 1'b0;
         valid_q      <= 1'b0;
         ts_1_valid_q <= 1'b0;

         case (state_q)
            IDLE: begin
               if (ptp_send_req && outptp_ready) begin
                  ack_q  <= 1'b1;
                  type_q <= ptp_send_type;
                  key_q  <= key;
                  ts4_q  <= ts_4_time;
                  // Unknown types are acknowledged and discarded.
                  if (type_ok_d) begin
                     state_q <= MD0;
                  end
               end
            end
            MD0: begin
               data_wr_q <= 1'b1;
               data_q    <= word_d;
               t_md_q    <= timer;
               state_q   <= MD1;
            end
            MD1: begin
               data_wr_q <= 1'b1;
               data_q    <= word_d;
               state_q   <= ETH;
            end
            ETH: begin
               data_wr_q <= 1'b1;
               data_q    <= word_d;
               state_q   <= PTP1;
            end
            PTP1: begin
               data_wr_q <= 1'b1;
               data_q    <= word_d;
               state_q   <= PTP2;
            end
            PTP2: begin
               data_wr_q <= 1'b1;
               data_q    <= word_d;
               state_q   <= PTP3;
            end
            PTP3: begin
               data_wr_q  <= 1'b1;
               data_q     <= word_d;
               valid_wr_q <= 1'b1;
               valid_q    <= 1'b1;
               case (type_q)
                  TYPE_SYNC: begin
                     ts_1_q       <= t_md_q;
                     ts_1_valid_q <= 1'b1;
                     t1_cnt_q     <= t1_cnt_q + 32'd1;
                  end
                  TYPE_DREQ:  t3_cnt_q <= t3_cnt_q + 32'd1;
                  TYPE_DRESP: t4_cnt_q <= t4_cnt_q + 32'd1;
                  default: ;
               endcase
               state_q <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign ptp_send_ack    = ack_q;
   assign outptp_data_wr  = data_wr_q;
   assign outptp_data     = data_q;
   assign outptp_valid_wr = valid_wr_q;
   assign outptp_valid    = valid_q;
   assign ts_1_valid      = ts_1_valid_q;
   assign ts_1            = ts_1_q;
   assign tx_t1_count     = t1_cnt_q;
   assign tx_t3_count     = t3_cnt_q;
   assign tx_t4_count     = t4_cnt_q;
   assign dbg_state       = state_q;

endmodule

// File: tb/tb_ptp_tx_gen.sv
module tb_ptp_tx_gen;

   localparam logic [47:0] PTP_DMAC = 48'h011B19000000;
   localparam logic [47:0] LMAC     = 48'h0;
   localparam logic [15:0] ETYPE    = 16'h88F7;

   // ---------------- clock / reset ----------------
   logic         clk = 1'b0;
   logic         reset;
   logic         ptp_send_req;
   logic [3:0]   ptp_send_type;
   logic [53:0]  key;
   logic [47:0]  ts_4_time;
   logic [47:0]  timer;
   logic         ptp_send_ack;
   logic         outptp_data_wr;
   logic [133:0] outptp_data;
   logic         outptp_valid_wr;
   logic         outptp_valid;
   logic         outptp_ready;
   logic         ts_1_valid;
   logic [47:0]  ts_1;
   logic [31:0]  tx_t1_count;
   logic [31:0]  tx_t3_count;
   logic [31:0]  tx_t4_count;
   logic [2:0]   dbg_state;

   always #5 clk = ~clk;

   ptp_tx_gen dut (
      .clk             (clk),
      .reset           (reset),
      .ptp_send_req    (ptp_send_req),
      .ptp_send_type   (ptp_send_type),
      .key             (key),
      .ts_4_time       (ts_4_time),
      .timer           (timer),
      .ptp_send_ack    (ptp_send_ack),
      .outptp_data_wr  (outptp_data_wr),
      .outptp_data     (outptp_data),
      .outptp_valid_wr (outptp_valid_wr),
      .outptp_valid    (outptp_valid),
      .outptp_ready    (outptp_ready),
      .ts_1_valid      (ts_1_valid),
      .ts_1            (ts_1),
      .tx_t1_count     (tx_t1_count),
      .tx_t3_count     (tx_t3_count),
      .tx_t4_count     (tx_t4_count),
      .dbg_state       (dbg_state)
   );

   // ---------------- scoreboard ----------------
   int tests_run = 0;
   int tests_failed = 0;
   logic [133:0] exp_q[$];

   task automatic check(input string tag, input logic [133:0] act, input logic [133:0] exp);
      tests_run++;
      if (act !== exp) begin
         tests_failed++;
         $display("FAIL %s: got %h expected %h", tag, act, exp);
      end
   endtask

   // ---------------- driver tasks ----------------
   logic [133:0] fw[6];
   logic         fwr[6];
   logic         fvwr[6];
   logic         fvalid[6];
   logic         fts1v[6];

   // Advance one clock; outputs are sampled 1 ns after the edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic get_frame();
      for (int i = 0; i < 6; i++) begin
         step();
         fw[i]     = outptp_data;
         fwr[i]    = outptp_data_wr;
         fvwr[i]   = outptp_valid_wr;
         fvalid[i] = outptp_valid;
         fts1v[i]  = ts_1_valid;
         // Move the timer on after the metadata word so a late sample shows up.
         if (i == 0) timer = timer + 48'd40;
      end
   endtask

   // Compare the captured frame against the words queued in exp_q.
   task automatic check_frame(input string tag, input logic sync);
      logic [133:0] e;
      for (int i = 0; i < 6; i++) begin
         check($sformatf("%s_wr%0d", tag, i), fwr[i], 1'b1);
         check($sformatf("%s_vwr%0d", tag, i), fvwr[i], (i == 5));
         check($sformatf("%s_ts1v%0d", tag, i), fts1v[i], (sync && i == 5));
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check($sformatf("%s_word%0d", tag, i), fw[i], e);
         end else begin
            check($sformatf("%s_expq_empty%0d", tag, i), 1'b1, 1'b0);
         end
      end
      check({tag, "_valid"}, fvalid[5], 1'b1);
      check({tag, "_idle"}, dbg_state, 3'd0);
   endtask

   task automatic push_frame(input logic [5:0] port, input logic [47:0] tmd,
                             input logic [47:0] dmac, input logic [3:0] typ,
                             input logic [47:0] tsf);
      exp_q.push_back({2'b01, 4'h0, 2'b00, port, 72'h0, tmd});
      exp_q.push_back({2'b11, 132'h0});
      exp_q.push_back({2'b11, 4'h0, dmac, LMAC, ETYPE, 4'h0, typ, 8'h0});
      exp_q.push_back({2'b11, 132'h0});
      exp_q.push_back({2'b11, 132'h0});
      exp_q.push_back({2'b10, 4'h0, 32'h0, tsf, 48'h0});
   endtask

   // ---------------- stimulus ----------------
   int ack_cyc[$];
   logic wrh[40];
   int  nwr;

   initial begin
      reset = 1'b1;
      ptp_send_req = 1'b0;
      ptp_send_type = 4'd0;
      key = 54'h0;
      ts_4_time = 48'h0;
      timer = 48'h0;
      outptp_ready = 1'b1;

      // Reset state
      step(); step();
      check("rst_state", dbg_state, 3'd0);
      check("rst_ack", ptp_send_ack, 1'b0);
      check("rst_wr", outptp_data_wr, 1'b0);
      check("rst_data", outptp_data, 134'h0);
      check("rst_t1", tx_t1_count, 32'h0);
      check("rst_ts1", ts_1, 48'h0);

      // Sync, requested in the first cycle after reset release
      reset = 1'b0;
      ptp_send_req = 1'b1;
      ptp_send_type = 4'd1;
      key = {48'h0, 6'd3};
      timer = 48'h0000_0001_E847;
      step();
      check("sync_ack", ptp_send_ack, 1'b1);
      ptp_send_req = 1'b0;
      push_frame(6'd3, 48'h0000_0001_E847, PTP_DMAC, 4'd1, 48'h0000_0001_E847);
      get_frame();
      check_frame("sync", 1'b1);
      check("sync_ts1", ts_1, 48'h0000_0001_E847);
      check("sync_t1cnt", tx_t1_count, 32'd1);
      step();
      check("sync_post_wr", outptp_data_wr, 1'b0);
      check("sync_post_ts1v", ts_1_valid, 1'b0);
      check("sync_hold_data", outptp_data, {2'b10, 4'h0, 32'h0, 48'h0000_0001_E847, 48'h0});

      // Delay_Resp with explicit MAC
      ptp_send_req = 1'b1;
      ptp_send_type = 4'd4;
      key = {48'hAABBCCDDEEFF, 6'd5};
      ts_4_time = 48'h1234_5678_9ABC;
      timer = 48'h0000_0100_0010;
      step();
      check("dresp_ack", ptp_send_ack, 1'b1);
      ptp_send_req = 1'b0;
      ts_4_time = 48'h0;
      push_frame(6'd5, 48'h0000_0100_0010, 48'hAABBCCDDEEFF, 4'd4, 48'h1234_5678_9ABC);
      get_frame();
      check_frame("dresp", 1'b0);
      check("dresp_t4cnt", tx_t4_count, 32'd1);
      check("dresp_t1cnt", tx_t1_count, 32'd1);
      check("dresp_ts1", ts_1, 48'h0000_0001_E847);

      // Back-pressure: held off while ready=0
      outptp_ready = 1'b0;
      ptp_send_req = 1'b1;
      ptp_send_type = 4'd3;
      key = {48'h0, 6'd9};
      timer = 48'h0000_0200_1E84;
      nwr = 0;
      for (int i = 0; i < 3; i++) begin
         step();
         check($sformatf("bp_noack%0d", i), ptp_send_ack, 1'b0);
         nwr += int'(outptp_data_wr);
      end
      check("bp_nowr", nwr, 0);
      outptp_ready = 1'b1;
      step();
      check("bp_ack", ptp_send_ack, 1'b1);
      ptp_send_req = 1'b0;
      outptp_ready = 1'b0;  // mid-frame drop must not stall
      push_frame(6'd9, 48'h0000_0200_1E84, PTP_DMAC, 4'd3, 48'h0);
      get_frame();
      check_frame("dreq", 1'b0);
      check("dreq_t3cnt", tx_t3_count, 32'd1);
      outptp_ready = 1'b1;

      // Back-to-back: request held every cycle
      ptp_send_req = 1'b1;
      ptp_send_type = 4'd1;
      key = 54'h0;
      for (int c = 0; c < 23; c++) begin
         step();
         if (ptp_send_ack) ack_cyc.push_back(c);
         wrh[c] = outptp_data_wr;
      end
      ptp_send_req = 1'b0;
      check("b2b_nacks", ack_cyc.size(), 4);
      for (int k = 1; k < ack_cyc.size(); k++) begin
         check($sformatf("b2b_gap%0d", k), ack_cyc[k] - ack_cyc[k-1], 7);
      end
      if (ack_cyc.size() > 0) begin
         check("b2b_first", ack_cyc[0], 0);
         nwr = 0;
         for (int c = 1; c < 22; c++) nwr += int'(wrh[c]);
         // Three complete frames in cycles 1..21, idle only on ack cycles.
         check("b2b_words", nwr, 18);
      end
      for (int i = 0; i < 8; i++) step();
      check("b2b_t1cnt", tx_t1_count, 32'd5);

      // Unsupported type 2: acked, no words, counters unchanged
      ptp_send_req = 1'b1;
      ptp_send_type = 4'd2;
      step();
      check("t2_ack", ptp_send_ack, 1'b1);
      ptp_send_req = 1'b0;
      nwr = 0;
      for (int i = 0; i < 8; i++) begin
         step();
         nwr += int'(outptp_data_wr) + int'(outptp_valid_wr);
      end
      check("t2_nowr", nwr, 0);
      check("t2_cnts", {tx_t1_count, tx_t3_count, tx_t4_count}, {32'd5, 32'd1, 32'd1});

      // Reset at the PTP1 cycle abandons the frame
      ptp_send_req = 1'b1;
      ptp_send_type = 4'd1;
      step();
      check("rmf_ack", ptp_send_ack, 1'b1);
      ptp_send_req = 1'b0;
      step(); step(); step();
      check("rmf_in_ptp1", dbg_state, 3'd4);
      reset = 1'b1;
      step();
      check("rmf_state", dbg_state, 3'd0);
      check("rmf_wr", outptp_data_wr, 1'b0);
      check("rmf_data", outptp_data, 134'h0);
      check("rmf_cnts", {tx_t1_count, tx_t3_count, tx_t4_count, ts_1}, 144'h0);
      reset = 1'b0;
      nwr = 0;
      for (int i = 0; i < 4; i++) begin
         step();
         nwr += int'(outptp_data_wr) + int'(outptp_valid_wr);
      end
      check("rmf_notail", nwr, 0);

      // Counter wrap on Delay_Req
      dut.t3_cnt_q = 32'hFFFF_FFFF;
      ptp_send_req = 1'b1;
      ptp_send_type = 4'd3;
      key = {48'h0, 6'd1};
      timer = 48'h0000_0300_0000;
      step();
      check("wrap_ack", ptp_send_ack, 1'b1);
      ptp_send_req = 1'b0;
      push_frame(6'd1, 48'h0000_0300_0000, PTP_DMAC, 4'd3, 48'h0);
      get_frame();
      check_frame("wrap", 1'b0);
      check("wrap_t3cnt", tx_t3_count, 32'h0);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

   // Global time limit
   initial begin
      #200000;
      $display("FAIL timeout: got running expected finished");
      $fatal(1, "timeout");
   end

endmodule
